// File: rtl/im_fetch_if.sv
// rtl/im_fetch_if.sv - fetch request/response handshake bundle for im_fetch
//
// Purpose : groups the request channel (req_*) and the response channel
//           (rsp_*) of the instruction fetch memory into one interface.
// Ports   : req_valid/req_ready/req_pc          - fetch request handshake
//           rsp_valid/rsp_ready                 - response handshake
//           rsp_instruction/rsp_pc/rsp_fault    - response payload
// Modports: master - the fetch unit (drives requests, consumes responses)
//           slave  - im_fetch (accepts requests, produces responses)
interface im_fetch_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_pc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instruction;
    logic [31:0]       rsp_pc;
    logic [1:0]        rsp_fault;

    modport master (
        output req_valid,
        output req_pc,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_instruction,
        input  rsp_pc,
        input  rsp_fault
    );

    modport slave (
        input  req_valid,
        input  req_pc,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_instruction,
        output rsp_pc,
        output rsp_fault
    );
endinterface

// File: rtl/im_fetch.sv
// rtl/im_fetch.sv - pipelined instruction memory with 2-entry response queue
//
// Purpose : accepts PC fetch requests, reads ins_memory at acceptance and
//           queues {instruction, pc, fault} in a 2-entry response queue that
//           absorbs back-pressure. Misaligned / out-of-range PCs return a
//           fault code with instruction 0 instead of aliasing.
// Ports   : clk      - clock, rising edge
//           reset    - asynchronous, active-high reset
//           bus      - im_fetch_if.slave (req_* / rsp_* handshakes)
//           flush    - drops all queued responses, blocks acceptance this cycle
//           ld_en    - boot-load write enable
//           ld_addr  - boot-load word index
//           ld_data  - boot-load word
// Config  : IM_BOOT_LOAD_EN - when defined, ld_* write ins_memory; otherwise
//           ld_* are ignored and the array is a ROM (hierarchical preload).
module im_fetch #(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h00003000,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    im_fetch_if.slave         bus,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam logic [32:0] SPAN = 33'(4 * DEPTH);

    localparam logic [1:0] FAULT_OK  = 2'b00;
    localparam logic [1:0] FAULT_MIS = 2'b01;
    localparam logic [1:0] FAULT_OOR = 2'b10;

    // Storage array; not reset so contents survive a reset.
    logic [DATA_W-1:0] ins_memory [0:DEPTH-1];

    // Response queue: slot 0 is the head and drives the outputs directly.
    logic [DATA_W-1:0] r_ins0, r_ins1;
    logic [31:0]       r_pc0,  r_pc1;
    logic [1:0]        r_fault0, r_fault1;
    logic [1:0]        r_occ;
    logic              r_live;

    logic [32:0]       w_offset;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic [1:0]        w_fault;
    logic [AW-1:0]     w_index;
    logic [DATA_W-1:0] w_rdata;
    logic              w_req_ready;
    logic              w_accept;
    logic              w_consume;

    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_wdata;

    // ------------------------------------------------------------------
    // Address decode. The subtraction is done 33 bits wide so a PC below
    // BASE_ADDR shows up as a borrow rather than wrapping into range.
    // ------------------------------------------------------------------
    assign w_offset       = {1'b0, bus.req_pc} - {1'b0, BASE_ADDR};
    assign w_misaligned   = |bus.req_pc[1:0];
    assign w_out_of_range = w_offset[32] || (w_offset >= SPAN);
    assign w_index        = w_offset[AW+1:2];

    always_comb begin
        w_fault = FAULT_OK;
        if (w_misaligned) begin
            w_fault = FAULT_MIS;
        end else if (w_out_of_range) begin
            w_fault = FAULT_OOR;
        end
    end

    // Faulted requests never touch the array; their payload is zero.
    always_comb begin
        w_rdata = '0;
        if (w_fault == FAULT_OK) begin
            w_rdata = ins_memory[w_index];
        end
    end

    // ------------------------------------------------------------------
    // Handshakes. req_ready depends only on registered state and flush so
    // no combinational path exists from rsp_ready back to req_ready.
    // ------------------------------------------------------------------
    assign w_req_ready = r_live && (r_occ != 2'd2) && !flush;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_consume   = (r_occ != 2'd0) && bus.rsp_ready;

    assign bus.req_ready       = w_req_ready;
    assign bus.rsp_valid       = (r_occ != 2'd0);
    assign bus.rsp_instruction = r_ins0;
    assign bus.rsp_pc          = r_pc0;
    assign bus.rsp_fault       = r_fault0;

    // ------------------------------------------------------------------
    // Queue update. A push lands in the first free slot after any pop in
    // the same cycle, which keeps responses in acceptance order.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live   <= 1'b0;
            r_occ    <= 2'd0;
            r_ins0   <= '0;
            r_pc0    <= '0;
            r_fault0 <= FAULT_OK;
            r_ins1   <= '0;
            r_pc1    <= '0;
            r_fault1 <= FAULT_OK;
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                // Accept is already blocked; a head consumed now is simply
                // dropped along with everything else.
                r_occ <= 2'd0;
            end else begin
                case ({w_accept, w_consume})
                    2'b10: begin
                        if (r_occ == 2'd0) begin
                            r_ins0   <= w_rdata;
                            r_pc0    <= bus.req_pc;
                            r_fault0 <= w_fault;
                        end else begin
                            r_ins1   <= w_rdata;
                            r_pc1    <= bus.req_pc;
                            r_fault1 <= w_fault;
                        end
                        r_occ <= r_occ + 2'd1;
                    end
                    2'b01: begin
                        r_ins0   <= r_ins1;
                        r_pc0    <= r_pc1;
                        r_fault0 <= r_fault1;
                        r_occ    <= r_occ - 2'd1;
                    end
                    2'b11: begin
                        if (r_occ == 2'd1) begin
                            r_ins0   <= w_rdata;
                            r_pc0    <= bus.req_pc;
                            r_fault0 <= w_fault;
                        end else begin
                            r_ins0   <= r_ins1;
                            r_pc0    <= r_pc1;
                            r_fault0 <= r_fault1;
                            r_ins1   <= w_rdata;
                            r_pc1    <= bus.req_pc;
                            r_fault1 <= w_fault;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Boot-load write port. The read above samples the old contents at the
    // same edge, giving read-first behaviour on a load/fetch collision.
    // ------------------------------------------------------------------
`ifdef IM_BOOT_LOAD_EN
    assign w_we = ld_en;
`else
    assign w_we = 1'b0;
    logic w_ld_en_unused;
    assign w_ld_en_unused = ld_en;
`endif
    assign w_waddr = ld_addr;
    assign w_wdata = ld_data;

    always_ff @(posedge clk) begin
        if (w_we) begin
            ins_memory[w_waddr] <= w_wdata;
        end
    end

endmodule

// File: tb/tb_im_fetch.sv
// tb/tb_im_fetch.sv - scoreboard testbench for im_fetch
module tb_im_fetch;

    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'h00003000;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [1:0]  fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    im_fetch_if #(.DATA_W(DATA_W)) bus ();

    im_fetch #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .flush   (flush),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          m_live  = 1'b0;
    logic [31:0] model_mem [0:DEPTH-1];
    exp_t        sb [$];
    logic [31:0] pend [$];

    function automatic exp_t model(input logic [31:0] pc);
        exp_t e;
        int   idx;
        e.pc    = pc;
        e.ins   = 32'h0;
        e.fault = 2'b00;
        if (pc[1:0] != 2'b00) begin
            e.fault = 2'b01;
        end else if (pc < 32'h3000 || pc >= 32'h4000) begin
            e.fault = 2'b10;
        end else begin
            idx   = int'((pc - 32'h3000) >> 2);
            e.ins = model_mem[idx];
        end
        return e;
    endfunction

    // One clock cycle: check outputs against the model, update the model
    // for this edge, then advance to the next falling edge.
    task automatic step(output bit acc);
        bit   exp_valid;
        bit   exp_ready;
        exp_t e;
        #1;
        exp_valid = (sb.size() != 0);
        exp_ready = m_live && (sb.size() < 2) && !flush;
        n_tests++;
        if (bus.req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL req_ready: got %b expected %b at %0t", bus.req_ready, exp_ready, $time);
        end
        n_tests++;
        if (bus.rsp_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL rsp_valid: got %b expected %b at %0t", bus.rsp_valid, exp_valid, $time);
        end
        if (exp_valid) begin
            e = sb[0];
            n_tests++;
            if (bus.rsp_instruction !== e.ins) begin
                n_fail++;
                $display("FAIL rsp_instruction: got %h expected %h (pc %h) at %0t", bus.rsp_instruction, e.ins, e.pc, $time);
            end
            n_tests++;
            if (bus.rsp_pc !== e.pc) begin
                n_fail++;
                $display("FAIL rsp_pc: got %h expected %h at %0t", bus.rsp_pc, e.pc, $time);
            end
            n_tests++;
            if (bus.rsp_fault !== e.fault) begin
                n_fail++;
                $display("FAIL rsp_fault: got %b expected %b (pc %h) at %0t", bus.rsp_fault, e.fault, e.pc, $time);
            end
            if (bus.rsp_ready) void'(sb.pop_front());
        end
        if (flush) sb.delete();
        acc = exp_ready && bus.req_valid;
        if (acc) sb.push_back(model(bus.req_pc));
`ifdef IM_BOOT_LOAD_EN
        if (ld_en) model_mem[ld_addr] = ld_data;
`endif
        @(posedge clk);
        if (!reset) m_live = 1'b1;
        @(negedge clk);
    endtask

    // Issue everything in pend and drain the scoreboard, bounded.
    task automatic stream(input int max_cycles, output int cycles);
        bit acc;
        cycles = 0;
        while ((pend.size() != 0 || sb.size() != 0) && cycles < max_cycles) begin
            bus.req_valid = (pend.size() != 0);
            bus.req_pc    = (pend.size() != 0) ? pend[0] : 32'h0;
            step(acc);
            if (acc) void'(pend.pop_front());
            cycles++;
        end
        bus.req_valid = 1'b0;
        n_tests++;
        if (pend.size() != 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL stream_timeout: %0d requests and %0d responses outstanding after %0d cycles", pend.size(), sb.size(), cycles);
        end
    endtask

    task automatic test_reset();
        bit acc;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
        n_tests++;
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        n_tests++;
        if (bus.rsp_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_instruction: got %h expected 0", bus.rsp_instruction); end
        n_tests++;
        if (bus.rsp_pc !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_pc: got %h expected 0", bus.rsp_pc); end
        n_tests++;
        if (bus.rsp_fault !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_fault: got %b expected 0", bus.rsp_fault); end
        reset = 1'b0;
        step(acc);
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_ready: got %b expected 1", bus.req_ready); end
    endtask

    task automatic test_back_to_back();
        int cycles;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) pend.push_back(BASE + 32'(4 * i));
        stream(200, cycles);
        n_tests++;
        if (cycles !== 21) begin
            n_fail++;
            $display("FAIL back_to_back_cycles: got %0d expected 21", cycles);
        end
    endtask

    task automatic test_faults();
        int cycles;
        bus.rsp_ready = 1'b1;
        pend.push_back(32'h00002FFC);
        pend.push_back(32'h00004000);
        pend.push_back(32'h00003002);
        pend.push_back(32'h00003008);
        pend.push_back(32'h00003FFC);
        pend.push_back(32'h00003001);
        pend.push_back(32'hFFFFFFFC);
        stream(100, cycles);
    endtask

    task automatic test_backpressure();
        bit acc;
        int cycles;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) pend.push_back(BASE + 32'(4 * i));
        for (int c = 0; c < 5; c++) begin
            bus.req_valid = 1'b1;
            bus.req_pc    = pend[0];
            step(acc);
            if (acc) void'(pend.pop_front());
        end
        n_tests++;
        if (pend.size() !== 6) begin
            n_fail++;
            $display("FAIL backpressure_accepts: got %0d accepted expected 2", 8 - pend.size());
        end
        bus.rsp_ready = 1'b1;
        stream(100, cycles);
    endtask

    task automatic test_flush();
        bit acc;
        int cycles;
        bus.rsp_ready = 1'b0;
        pend.push_back(32'h00003000);
        pend.push_back(32'h00003004);
        for (int c = 0; c < 3; c++) begin
            bus.req_valid = (pend.size() != 0);
            bus.req_pc    = (pend.size() != 0) ? pend[0] : 32'h0;
            step(acc);
            if (acc) void'(pend.pop_front());
        end
        // Flush cycle: head handshakes and a request is presented but must not be taken.
        flush         = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'h00003008;
        step(acc);
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        step(acc);
        pend.delete();
        pend.push_back(32'h00003010);
        stream(50, cycles);
    endtask

`ifdef IM_BOOT_LOAD_EN
    task automatic test_boot_load();
        bit acc;
        int cycles;
        bus.rsp_ready = 1'b1;
        ld_en         = 1'b1;
        ld_addr       = 10'd5;
        ld_data       = 32'hDEADBEEF;
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'h00003014;
        step(acc);
        ld_en = 1'b0;
        step(acc);
        bus.req_valid = 1'b0;
        stream(20, cycles);
        n_tests++;
        if (model_mem[5] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL boot_load_model: got %h expected deadbeef", model_mem[5]);
        end
    endtask
`endif

    task automatic test_reset_midop();
        bit acc;
        int cycles;
        bus.rsp_ready = 1'b0;
        pend.push_back(32'h00003000);
        pend.push_back(32'h00003004);
        for (int c = 0; c < 2; c++) begin
            bus.req_valid = 1'b1;
            bus.req_pc    = pend[0];
            step(acc);
            if (acc) void'(pend.pop_front());
        end
        bus.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midop_reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        n_tests++;
        if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL midop_reset_req_ready: got %b expected 0", bus.req_ready); end
        sb.delete();
        pend.delete();
        m_live = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset         = 1'b0;
        bus.rsp_ready = 1'b1;
        pend.push_back(32'h00003000);
        pend.push_back(32'h00003008);
        stream(50, cycles);
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        ld_en         = 1'b0;
        ld_addr       = '0;
        ld_data       = '0;
        bus.req_valid = 1'b0;
        bus.req_pc    = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            dut.ins_memory[i] = 32'(i);
            model_mem[i]      = 32'(i);
        end
        test_reset();
        test_back_to_back();
        test_faults();
        test_backpressure();
        test_flush();
`ifdef IM_BOOT_LOAD_EN
        test_boot_load();
`endif
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/im_fetch.md
# im_fetch

Parametrised, pipelined instruction memory for the processor's fetch path. Accepts PC fetch requests over a valid/ready handshake, returns the instruction word one cycle later through a 2-entry response queue that absorbs back-pressure, and flags misaligned or out-of-range PCs instead of aliasing them. It also provides a flush for redirects and an optional boot-load write port.

## Interface
- `DATA_W`, 32: instruction word width.
- `DEPTH`, 1024: number of words in `ins_memory`. Power of two.
- `BASE_ADDR`, 32'h00003000: byte address of word 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready` at a rising edge.
- `req_pc`  in  32  byte address to fetch.
- `flush`  in  1  discards all in-flight and queued responses.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_instruction`  out  DATA_W  fetched word; 0 when `rsp_fault != 0`.
- `rsp_pc`  out  32  PC of the returned word.
- `rsp_fault`  out  2  00 ok, 01 misaligned, 10 out of range.
- `ld_en`  in  1  boot-load write enable (IM_BOOT_LOAD_EN only).
- `ld_addr`  in  $clog2(DEPTH)  boot-load word index.
- `ld_data`  in  DATA_W  boot-load word.

## Operation
- The storage array is `ins_memory[0:DEPTH-1]`. It is not reset. Benches may preload it hierarchically.
- Word index = `(req_pc - BASE_ADDR) >> 2`.
- Fault decode happens at acceptance:
  - misaligned if `req_pc[1:0] != 0`;
  - out of range if `req_pc < BASE_ADDR` or `req_pc >= BASE_ADDR + 4*DEPTH`;
  - misaligned takes priority.
- A faulted request still produces a response, in order. No memory read is performed for it.
- Occupancy `occ` (0..2) counts accepted requests whose responses are not yet consumed, including the one being read.
- `req_ready = (occ < 2) && !flush`. It is driven from registered state and `flush` only. There is no combinational path from `rsp_ready`.
- `occ` update: +1 on accept, -1 on consume, unchanged when both occur in the same cycle.
- Responses are returned strictly in acceptance order.
- Outputs hold stable while `rsp_valid && !rsp_ready`.
- Flush:
  - the cycle after `flush` is sampled high, `occ = 0` and `rsp_valid = 0`;
  - a response handshaking in the flush cycle counts as consumed;
  - no request is accepted in the flush cycle.
- Reset values: `req_ready` 0 while `reset` is high and 1 on the first cycle after deassertion. `rsp_valid` 0, `rsp_instruction` 0, `rsp_pc` 0, `rsp_fault` 0, `occ` 0.
- Reset mid-operation drops all pending responses. Memory contents are retained.

## Timing
- Latency: request accepted at edge N gives `rsp_valid` high after edge N, if the queue was empty or its head was consumed at N.
- Throughput: one fetch per cycle sustained while `rsp_ready` is held high.
- With `rsp_ready` low, at most 2 requests are accepted, then `req_ready` falls. It rises the cycle after the next consume.
- Load/fetch collision: a load and a fetch to the same word at the same edge return the old word (read-first). The new word is visible to fetches accepted at later edges.

## Configuration
- `IM_BOOT_LOAD_EN` defined: `ld_en`/`ld_addr`/`ld_data` write `ins_memory[ld_addr] <= ld_data` on the rising edge when `ld_en` is high. This works during and after reset.
- Not defined: the ports still exist but are ignored. The memory is only writable hierarchically and synthesises as ROM.

## Test plan
- Preload `ins_memory[i] = i`. Back-to-back requests `0x3000, 0x3004, … 0x304C` with `rsp_ready = 1` -> 20 responses in consecutive cycles with `rsp_instruction = 0..19`, each `rsp_pc` matching its request, `rsp_fault = 0`.
- Requests `0x2FFC`, `0x4000`, `0x3002` -> `rsp_fault` = 10, 10, 01 respectively, with `rsp_instruction = 0`. A following `0x3008` returns 2 with fault 00.
- Hold `rsp_ready = 0` while streaming from `0x3000` -> `req_ready` low after 2 accepts. `rsp_instruction` holds 0 until released, then 0, 1 are delivered in order, then streaming resumes at 2.
- Accept `0x3000` and `0x3004`, stall, then pulse `flush` for one cycle -> next cycle `rsp_valid = 0`. A new `0x3010` is accepted after the flush and returns 4.
- With IM_BOOT_LOAD_EN: load `ld_addr = 5`, `ld_data = 32'hDEADBEEF`, and fetch `0x3014` at the same edge -> returns 5. A refetch at the next edge returns `DEADBEEF`.
- Assert `reset` with 2 responses pending -> `rsp_valid = 0` and `req_ready = 0` immediately. After release, `0x3000` returns 0.
